// File: rtl/gcd_job_dispatcher.sv
// Host-side sequencer for the subtract-and-compare GCD engine: queues operand
// pairs, drives the engine load/start handshake and returns results in order.
`timescale 1ns/1ps
module gcd_job_dispatcher #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             eng_load,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             eng_start,
  output logic             eng_abort,
  input  logic             eng_result,
  input  logic [WIDTH-1:0] eng_value
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(START_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wptr, r_rptr;
  logic               r_in_ready;
  state_t             r_state;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_byp;
  logic [SW-1:0]      r_scnt;
  logic [TW-1:0]      r_wd;
  logic               r_out_valid, r_out_err;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_eng_load, r_eng_start, r_eng_abort;
  logic [WIDTH-1:0]   r_eng_a, r_eng_b;

  logic               w_push, w_pop, w_empty, w_full_nxt;
  logic [PW-1:0]      w_wptr_nxt, w_rptr_nxt;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_head_a, w_head_b;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_a_nxt, w_b_nxt;
  logic               w_byp_nxt;
  logic [SW-1:0]      w_scnt_nxt;
  logic [TW-1:0]      w_wd_nxt;
  logic               w_out_valid_nxt, w_out_err_nxt;
  logic [WIDTH-1:0]   w_out_data_nxt;
  logic               w_eng_load_nxt, w_eng_start_nxt, w_eng_abort_nxt;
  logic [WIDTH-1:0]   w_eng_a_nxt, w_eng_b_nxt;

  // Queue pointers carry an extra wrap bit to tell full from empty.
  assign w_push     = in_valid & r_in_ready;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_head     = r_mem[r_rptr[AW-1:0]];
  assign w_head_a   = w_head[2*WIDTH-1:WIDTH];
  assign w_head_b   = w_head[WIDTH-1:0];
  assign w_wptr_nxt = r_wptr + PW'(w_push);
  assign w_rptr_nxt = r_rptr + PW'(w_pop);
  assign w_full_nxt = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                      (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_in_ready <= ~w_full_nxt;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_byp_nxt       = r_byp;
    w_scnt_nxt      = r_scnt;
    w_wd_nxt        = r_wd;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_err_nxt   = r_out_err;
    w_eng_load_nxt  = 1'b0;
    w_eng_start_nxt = 1'b0;
    w_eng_abort_nxt = 1'b0;
    w_eng_a_nxt     = r_eng_a;
    w_eng_b_nxt     = r_eng_b;
    case (r_state)
      S_IDLE: begin
        if (r_byp) begin
          // A zero operand never terminates in the engine; answer directly.
          w_byp_nxt       = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_a | r_b;
          w_out_err_nxt   = 1'b0;
        end else if (!w_empty && !r_out_valid) begin
          w_pop   = 1'b1;
          w_a_nxt = w_head_a;
          w_b_nxt = w_head_b;
          if ((w_head_a == '0) || (w_head_b == '0)) begin
            w_byp_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_LOAD;
            w_eng_load_nxt = 1'b1;
            w_eng_a_nxt    = w_head_a;
            w_eng_b_nxt    = w_head_b;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt     = S_START;
        w_eng_start_nxt = 1'b1;
        w_scnt_nxt      = SW'(1);
      end
      S_START: begin
        if (r_scnt == SW'(START_CYCLES)) begin
          w_state_nxt = S_WAIT;
          w_wd_nxt    = '0;
        end else begin
          w_eng_start_nxt = 1'b1;
          w_scnt_nxt      = r_scnt + SW'(1);
        end
      end
      S_WAIT: begin
        // A result in the final watchdog cycle takes priority over the abort.
        if (eng_result) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = eng_value;
          w_out_err_nxt   = 1'b0;
        end else if (r_wd == TW'(TIMEOUT - 1)) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = '0;
          w_out_err_nxt   = 1'b1;
          w_eng_abort_nxt = 1'b1;
        end else begin
          w_wd_nxt = r_wd + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_byp       <= 1'b0;
      r_scnt      <= '0;
      r_wd        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_eng_load  <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_byp       <= w_byp_nxt;
      r_scnt      <= w_scnt_nxt;
      r_wd        <= w_wd_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_err   <= w_out_err_nxt;
      r_eng_load  <= w_eng_load_nxt;
      r_eng_start <= w_eng_start_nxt;
      r_eng_abort <= w_eng_abort_nxt;
      r_eng_a     <= w_eng_a_nxt;
      r_eng_b     <= w_eng_b_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign eng_load  = r_eng_load;
  assign eng_a     = r_eng_a;
  assign eng_b     = r_eng_b;
  assign eng_start = r_eng_start;
  assign eng_abort = r_eng_abort;

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Bench for gcd_job_dispatcher: directed scenarios plus random jobs, checked
// against a queue-based reference model and a behavioural engine model.
`timescale 1ns/1ps
module tb_gcd_job_dispatcher;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_err;
  logic [W-1:0] out_data;
  logic         eng_load, eng_start, eng_abort, eng_result;
  logic [W-1:0] eng_a, eng_b, eng_value;

  always #5 clk = ~clk;

  gcd_job_dispatcher #(.WIDTH(W), .DEPTH(D), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .eng_load(eng_load), .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
    .eng_abort(eng_abort), .eng_result(eng_result), .eng_value(eng_value)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_load = 0;
  int n_abort = 0;
  int n_abort_exp = 0;
  bit bp_on = 1'b0;

  // Reference model state: expected results in order, and engine-bound jobs.
  logic [W-1:0] q_res_d [$];
  logic         q_res_e [$];
  logic [W-1:0] q_op_a [$];
  logic [W-1:0] q_op_b [$];
  int           q_dly [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // dly: WAIT cycle in which the engine answers; 0 means it never answers.
  task automatic model_job(input logic [W-1:0] a, input logic [W-1:0] b, input int dly);
    if (a == '0 || b == '0) begin
      q_res_d.push_back(a | b);
      q_res_e.push_back(1'b0);
    end else begin
      q_op_a.push_back(a);
      q_op_b.push_back(b);
      q_dly.push_back(dly);
      if (dly >= 1 && dly <= int'(TO)) begin
        q_res_d.push_back(gcd_ref(a, b));
        q_res_e.push_back(1'b0);
      end else begin
        q_res_d.push_back('0);
        q_res_e.push_back(1'b1);
        n_abort_exp++;
      end
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int dly);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        model_job(a, b, dly);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("push_accept_timeout", 0, 1);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q_res_d.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q_res_d.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Behavioural engine: answers with the true GCD a set number of WAIT cycles after start falls.
  int           eng_cnt = 0;
  int           eng_dly = 0;
  bit           eng_run = 1'b0;
  bit           prev_start = 1'b0;
  logic [W-1:0] eng_g = '0;
  initial begin
    eng_result = 1'b0;
    eng_value  = '0;
    forever begin
      @(negedge clk);
      eng_result = 1'b0;
      if (rst) begin
        eng_run = 1'b0;
        prev_start = 1'b0;
        continue;
      end
      if (eng_abort) begin
        chk("timeout_wait_cycles", eng_cnt, TO);
        eng_run = 1'b0;
      end
      if (eng_load) begin
        if (q_op_a.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          chk("eng_a", eng_a, q_op_a.pop_front());
          chk("eng_b", eng_b, q_op_b.pop_front());
          eng_dly = q_dly.pop_front();
          eng_g   = gcd_ref(eng_a, eng_b);
          eng_run = 1'b0;
        end
      end
      if (prev_start && !eng_start) begin
        eng_run = 1'b1;
        eng_cnt = 0;
      end
      prev_start = eng_start;
      if (eng_run) begin
        eng_cnt++;
        if (eng_cnt == eng_dly) begin
          eng_result = 1'b1;
          eng_value  = eng_g;
          eng_run    = 1'b0;
        end
      end
    end
  end

  // Output scoreboard and protocol monitors.
  bit           hold = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         hold_e = 1'b0;
  int           start_len = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
        start_len = 0;
        continue;
      end
      if (hold) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, hold_d);
        chk("out_hold_err", out_err, hold_e);
      end
      if (out_valid && out_ready) begin
        if (q_res_d.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("out_data", out_data, q_res_d.pop_front());
          chk("out_err", out_err, q_res_e.pop_front());
        end
      end
      hold   = out_valid && !out_ready;
      hold_d = out_data;
      hold_e = out_err;
      if (eng_load) n_load++;
      if (eng_abort) n_abort++;
      if (eng_start) begin
        start_len++;
      end else if (start_len != 0) begin
        chk("start_len", start_len, SC);
        start_len = 0;
      end
    end
  end

  // Random backpressure, changed just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_on) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_err"}, out_err, 0);
    chk({pfx, "_eng_load"}, eng_load, 0);
    chk({pfx, "_eng_start"}, eng_start, 0);
    chk({pfx, "_eng_abort"}, eng_abort, 0);
    chk({pfx, "_eng_a"}, eng_a, 0);
    chk({pfx, "_eng_b"}, eng_b, 0);
  endtask

  initial begin
    int loads0;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1;
    chk_reset_vals("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single job (12,18): load latency, start width, result 6.
    loads0 = n_load;
    push(8'd12, 8'd18, 12);
    chk("load_early", eng_load, 0);
    @(negedge clk);
    chk("load_lat", eng_load, 1);
    @(negedge clk);
    chk("start_c1", eng_start, 1);
    @(negedge clk);
    chk("start_c2", eng_start, 1);
    @(negedge clk);
    chk("start_off", eng_start, 0);
    drain();
    chk("single_loads", n_load - loads0, 1);

    // Zero bypass: result two cycles after the push, engine untouched.
    loads0 = n_load;
    for (int k = 0; k < 3; k++) begin
      ra = (k == 0) ? 8'd0 : (k == 1) ? 8'd0 : 8'd7;
      rb = (k == 0) ? 8'd9 : 8'd0;
      push(ra, rb, 0);
      @(negedge clk);
      chk("byp_early", out_valid, 0);
      @(negedge clk);
      chk("byp_lat", out_valid, 1);
      chk("byp_val", out_data, ra | rb);
      repeat (2) @(negedge clk);
    end
    drain();
    chk("byp_loads", n_load - loads0, 0);
    chk("byp_start", start_len, 0);

    // Queue full under backpressure, then release.
    set_rdy(1'b0);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) push(W'(6 * k), W'(4 * k), 3);
    chk("full_in_ready", in_ready, 0);
    fork
      push(8'd45, 8'd30, 3);
      begin
        repeat (10) @(negedge clk);
        chk("full_hold", in_ready, 0);
        set_rdy(1'b1);
      end
    join
    drain();

    // Timeout, then a normal job; then result on the final watchdog cycle.
    push(8'd21, 8'd14, 0);
    push(8'd9, 8'd6, 4);
    drain();
    chk("abort_after_timeout", n_abort, n_abort_exp);
    push(8'd10, 8'd15, int'(TO));
    drain();
    chk("abort_same_cycle", n_abort, n_abort_exp);

    // Random jobs with random backpressure.
    bp_on = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 4) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      push(ra, rb, int'($urandom_range(0, TO + 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    bp_on = 1'b0;
    set_rdy(1'b1);
    drain();
    chk("abort_random", n_abort, n_abort_exp);

    // Reset mid-WAIT with jobs still queued.
    for (int k = 0; k < 3; k++) push(W'(21 + k), 8'd14, 0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    q_res_d.delete();
    q_res_e.delete();
    q_op_a.delete();
    q_op_b.delete();
    q_dly.delete();
    n_abort_exp = n_abort;
    loads0 = n_load;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_loads", n_load - loads0, 0);
    chk("post_rst_aborts", n_abort, n_abort_exp);
    chk("post_rst_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
